// File: rtl/weight_store_mc_pkg.sv
// Shared types and helpers for the multi-lane weight store.
// Holds the FSM state encoding and LFSR tap selection.
package weight_store_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_INIT,
        ST_XFER
    } state_e;

    // Maximal-length Fibonacci tap masks, bit n = stage n (0-based)
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] m;
        case (width)
            4:       m = 16'h000C;
            5:       m = 16'h0014;
            6:       m = 16'h0030;
            7:       m = 16'h0060;
            8:       m = 16'h00B8;
            9:       m = 16'h0110;
            10:      m = 16'h0240;
            11:      m = 16'h0500;
            12:      m = 16'h0829;
            13:      m = 16'h100D;
            14:      m = 16'h2015;
            15:      m = 16'h6000;
            16:      m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_store_mc_if.sv
// Control/data bundle between the controller and the weight store.
// Master drives requests, slave returns status and read data.
interface weight_store_mc_if #(
    parameter int WIDTH  = 10,
    parameter int LANES  = 10,
    parameter int ADDR_W = 7
);
    logic                         InitReq;
    logic                         Req;
    logic                         WE;
    logic [ADDR_W-1:0]            Address;
    logic [LANES-1:0][WIDTH-1:0]  D;
    logic                         Ack;
    logic                         AddrErr;
    logic [LANES-1:0][WIDTH-1:0]  Q;
    logic                         Busy;
    logic                         InitDone;

    modport master (
        output InitReq, Req, WE, Address, D,
        input  Ack, AddrErr, Q, Busy, InitDone
    );

    modport slave (
        input  InitReq, Req, WE, Address, D,
        output Ack, AddrErr, Q, Busy, InitDone
    );
endinterface

// File: rtl/weight_store_mc_lfsr.sv
// Fibonacci LFSR used as the random source for weight fills.
// Advances only when i_Adv is high; free of any reseed path.
module weight_lfsr
    import weight_store_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             i_Clock,
    input  logic             i_Rst,
    input  logic             i_Adv,
    output logic [WIDTH-1:0] o_State
);
    localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_q;
    logic             w_fb;

    assign w_fb    = ^(r_q & TAPS);
    assign o_State = r_q;

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            r_q <= SEED;
        end else if (i_Adv) begin
            r_q <= {r_q[WIDTH-2:0], w_fb};
        end
    end
endmodule

// File: rtl/weight_store_mc.sv
// Multi-lane weight memory: LFSR fill, then LANES-wide burst access.
// Accesses resolve on the accepting edge; XFER is the ack/status cycle.
module weight_store_mc
    import weight_store_pkg::*;
#(
    parameter int               WIDTH  = 10,
    parameter int               DEPTH  = 65,
    parameter int               LANES  = 10,
    parameter int               ADDR_W = 7,
    parameter int               WRAP   = 0,
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(1)
) (
    input  logic             i_Clock,
    input  logic             i_Rst,
    weight_store_mc_if.slave bus
);
    localparam int AW1   = ADDR_W + 1;
    localparam int IDX_W = clog2(DEPTH);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [AW1-1:0]   DEPTH_A  = AW1'(DEPTH);
    localparam logic [AW1-1:0]   LANES_A  = AW1'(LANES);

    state_e                      r_state;
    logic [IDX_W-1:0]            r_idx;
    logic                        r_ack;
    logic                        r_err;
    logic                        r_busy;
    logic                        r_done;
    logic [LANES-1:0][WIDTH-1:0] r_q;
    logic [WIDTH-1:0]            r_mem [DEPTH];

    logic [WIDTH-1:0]  w_rnd;
    logic              w_init;
    logic              w_err;
    logic              w_accept;
    logic              w_wr;
    logic [AW1-1:0]    w_base;
    logic [AW1-1:0]    w_sum  [LANES];
    logic [ADDR_W-1:0] w_lane [LANES];

    weight_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .i_Clock (i_Clock),
        .i_Rst   (i_Rst),
        .i_Adv   (w_init),
        .o_State (w_rnd)
    );

    assign w_init   = (r_state == ST_INIT);
    assign w_base   = {1'b0, bus.Address};
    assign w_accept = !w_init && !bus.InitReq && bus.Req;
    assign w_wr     = i_Rst && w_accept && bus.WE && !w_err;

    // Range check runs one bit wider so Address+LANES cannot alias
    assign w_err = (WRAP != 0) ? (w_base >= DEPTH_A)
                               : ((w_base + LANES_A) > DEPTH_A);

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_sum[i]  = w_base + AW1'(i);
            w_lane[i] = w_sum[i][ADDR_W-1:0];
            if (WRAP != 0 && w_sum[i] >= DEPTH_A) begin
                w_lane[i] = ADDR_W'(w_sum[i] - DEPTH_A);
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge i_Clock) begin
        if (w_init) begin
            r_mem[r_idx] <= w_rnd;
        end else if (w_wr) begin
            for (int i = 0; i < LANES; i++) begin
                r_mem[w_lane[i]] <= bus.D[i];
            end
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= '0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IDX_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_IDLE, ST_XFER: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (bus.InitReq) begin
                        r_state <= ST_INIT;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                    end else if (bus.Req) begin
                        r_state <= ST_XFER;
                        r_busy  <= 1'b1;
                        if (w_err) begin
                            r_err <= 1'b1;
                        end else begin
                            r_ack <= 1'b1;
                            if (!bus.WE) begin
                                for (int i = 0; i < LANES; i++) begin
                                    r_q[i] <= r_mem[w_lane[i]];
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Ack      = r_ack;
    assign bus.AddrErr  = r_err;
    assign bus.Q        = r_q;
    assign bus.Busy     = r_busy;
    assign bus.InitDone = r_done;
endmodule

// File: tb/tb_weight_store_mc.sv
// Scoreboard bench for weight_store_mc: no-wrap and wrap instances.
// Stimulus pushes expected responses; a negedge monitor checks them.
module tb_weight_store_mc;
    typedef logic [9:0][9:0] vec_t;
    typedef struct {
        bit   err;
        vec_t q;
        int   cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t qa[$];
    exp_t qb[$];
    vec_t qa_last;
    vec_t qb_last;

    weight_store_mc_if #(.WIDTH(10), .LANES(10), .ADDR_W(7)) ifa ();
    weight_store_mc_if #(.WIDTH(10), .LANES(10), .ADDR_W(7)) ifb ();

    weight_store_mc #(.WRAP(0)) u_a (
        .i_Clock (clk),
        .i_Rst   (rst_n),
        .bus     (ifa)
    );

    weight_store_mc #(.WRAP(1)) u_b (
        .i_Clock (clk),
        .i_Rst   (rst_n),
        .bus     (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic vec_t ramp(input int base);
        vec_t v;
        for (int i = 0; i < 10; i++) v[i] = 10'(base + i);
        return v;
    endfunction

    function automatic logic [9:0] lstep(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    // Words produced after skipping n LFSR steps from the seed
    function automatic vec_t lfsr_words(input int n);
        logic [9:0] s;
        vec_t v;
        s = 10'h001;
        for (int i = 0; i < n; i++) s = lstep(s);
        for (int i = 0; i < 10; i++) begin
            v[i] = s;
            s = lstep(s);
        end
        return v;
    endfunction

    task automatic mon(input bit sel, input logic ack, input logic err,
                       input vec_t q);
        exp_t  e;
        string p;
        bit    empty;
        p = sel ? "b" : "a";
        if (ack || err) begin
            chk({p, "_ack_err_exclusive"}, {127'b0, ack & err}, 0);
            empty = sel ? (qb.size() == 0) : (qa.size() == 0);
            if (empty) begin
                chk({p, "_unexpected_response"}, 1, 0);
            end else begin
                if (sel) e = qb.pop_front();
                else     e = qa.pop_front();
                chk({p, "_resp_kind_err"}, {127'b0, err}, {127'b0, e.err});
                chk({p, "_resp_q"}, q, e.q);
                chk({p, "_resp_latency"}, cyc, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(1'b0, ifa.Ack, ifa.AddrErr, ifa.Q);
            mon(1'b1, ifb.Ack, ifb.AddrErr, ifb.Q);
        end
    end

    task automatic access(input bit sel, input bit we, input int addr,
                          input vec_t d, input bit err, input vec_t q);
        exp_t e;
        e.err = err;
        e.cyc = cyc + 1;
        if (sel) begin
            if (!err && !we) qb_last = q;
            e.q = qb_last;
            ifb.Req = 1'b1; ifb.WE = we;
            ifb.Address = 7'(addr); ifb.D = d;
            qb.push_back(e);
        end else begin
            if (!err && !we) qa_last = q;
            e.q = qa_last;
            ifa.Req = 1'b1; ifa.WE = we;
            ifa.Address = 7'(addr); ifa.D = d;
            qa.push_back(e);
        end
        @(posedge clk); #1;
        ifa.Req = 1'b0;
        ifb.Req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wait_fill(output int cnt);
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ifa.Busy) cnt++;
            else break;
        end
        @(posedge clk); #1;
    endtask

    task automatic pulse_init(input bit both);
        ifa.InitReq = 1'b1;
        ifb.InitReq = both;
        @(posedge clk); #1;
        ifa.InitReq = 1'b0;
        ifb.InitReq = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   n;
        vec_t v;
        vec_t z;
        checks   = 0;
        failures = 0;
        z        = '0;
        qa_last  = '0;
        qb_last  = '0;
        ifa.InitReq = 0; ifa.Req = 0; ifa.WE = 0; ifa.Address = 0; ifa.D = '0;
        ifb.InitReq = 0; ifb.Req = 0; ifb.WE = 0; ifb.Address = 0; ifb.D = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {127'b0, ifa.Busy}, 0);
        chk("rst_ack", {127'b0, ifa.Ack}, 0);
        chk("rst_addrerr", {127'b0, ifa.AddrErr}, 0);
        chk("rst_initdone", {127'b0, ifa.InitDone}, 0);
        chk("rst_q", ifa.Q, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        pulse_init(1'b1);
        wait_fill(n);
        chk("fill_busy_cycles", n, 65);
        chk("fill_initdone_a", {127'b0, ifa.InitDone}, 1);
        chk("fill_initdone_b", {127'b0, ifb.InitDone}, 1);

        v = {10'h204, 10'h102, 10'h081, 10'h040, 10'h020,
             10'h010, 10'h008, 10'h004, 10'h002, 10'h001};
        access(0, 0, 0, z, 0, v);

        access(0, 1, 20, ramp(10'h100), 0, z);
        access(0, 0, 20, z, 0, ramp(10'h100));
        v = ramp(10'h0FF); v[0] = 10'h220;
        access(0, 0, 19, z, 0, v);
        v = ramp(10'h101); v[9] = 10'h24D;
        access(0, 0, 21, z, 0, v);

        access(0, 1, 55, ramp(10'h300), 0, z);
        access(0, 0, 60, z, 1, z);
        access(0, 1, 60, ramp(10'h3C0), 1, z);
        access(0, 0, 56, z, 1, z);
        access(0, 0, 55, z, 0, ramp(10'h300));

        access(1, 1, 60, ramp(10'h200), 0, z);
        access(1, 0, 60, z, 0, ramp(10'h200));
        v = {10'h204, 10'h102, 10'h081, 10'h040, 10'h020,
             10'h209, 10'h208, 10'h207, 10'h206, 10'h205};
        access(1, 0, 0, z, 0, v);
        access(1, 0, 65, z, 1, z);

        ifa.InitReq = 1'b1; ifa.Req = 1'b1; ifa.WE = 1'b1;
        ifa.Address = 7'd0; ifa.D = ramp(10'h3A0);
        @(posedge clk); #1;
        ifa.InitReq = 1'b0;
        repeat (3) @(posedge clk);
        #1 ifa.Req = 1'b0;
        wait_fill(n);
        chk("fill2_busy_after_req", n, 62);
        access(0, 0, 0, z, 0, lfsr_words(65));

        pulse_init(1'b0);
        repeat (30) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {127'b0, ifa.Busy}, 0);
        chk("midrst_initdone", {127'b0, ifa.InitDone}, 0);
        chk("midrst_q", ifa.Q, 0);
        chk("midrst_ack", {127'b0, ifa.Ack}, 0);
        qa_last = '0;
        qb_last = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_initdone_after", {127'b0, ifa.InitDone}, 0);
        pulse_init(1'b0);
        wait_fill(n);
        chk("refill_busy_cycles", n, 65);
        chk("refill_initdone", {127'b0, ifa.InitDone}, 1);
        v = {10'h204, 10'h102, 10'h081, 10'h040, 10'h020,
             10'h010, 10'h008, 10'h004, 10'h002, 10'h001};
        access(0, 0, 0, z, 0, v);

        repeat (3) @(posedge clk);
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/weight_store_mc.md
Name: weight_store_mc

Overview:
- Parametrised, multi-lane weight memory. Successor to the single-mode weight initialiser.
- On request, fills every word with pseudo-random values from an internal LFSR, one word per cycle.
- Then serves LANES-wide burst reads and writes through a req/ack handshake.
- Sits between the training/control FSM and the neuron datapath. Adds a busy/done status, out-of-range detection and an optional address wrap mode.

Parameters:
- WIDTH, 10, bits per weight word
- DEPTH, 65, number of words stored
- LANES, 10, words transferred per access
- ADDR_W, 7, address width; must satisfy 2**ADDR_W >= DEPTH
- WRAP, 0, 1 = burst addresses wrap modulo DEPTH; 0 = an out-of-range burst is rejected
- SEED, 10'h001, LFSR reset value; must be nonzero

Ports:
- Clock  in  1  single clock; all state is updated on its rising edge
- Rst  in  1  asynchronous, active-low reset
- InitReq  in  1  pulse; start a random fill of all DEPTH words
- Req  in  1  access request; sampled only in IDLE
- WE  in  1  with Req: 1 = write D, 0 = read into Q
- Address  in  ADDR_W  base word of the burst
- D  in  LANES x WIDTH  write data; lane i goes to Address+i
- Ack  out  1  one-cycle pulse; the access has completed
- AddrErr  out  1  one-cycle pulse; the burst was rejected
- Q  out  LANES x WIDTH  read data; lane i comes from Address+i
- Busy  out  1  high while in INIT or XFER
- InitDone  out  1  high once a fill has completed; sticky

Behaviour:
- Reset (Rst=0, asynchronous):
  - State = IDLE; Ack=0, AddrErr=0, Busy=0, InitDone=0; all Q lanes = 0; LFSR = SEED.
  - Memory contents are not reset. Reset during INIT aborts the fill and leaves InitDone=0.
- States: IDLE, INIT, XFER.
- IDLE:
  - InitReq=1 -> INIT. Clear fill index; Busy=1 next cycle.
  - Else if Req=1 -> XFER, latching Address, WE and D.
  - InitReq and Req high together: InitReq wins; Req is dropped with no Ack.
- INIT:
  - Each cycle: mem[idx] <= LFSR state, LFSR steps, idx++.
  - After writing idx = DEPTH-1: -> IDLE, InitDone=1. The fill takes exactly DEPTH cycles.
  - Req and InitReq are ignored while in INIT.
  - Q is held unchanged during INIT.
- LFSR:
  - Fibonacci form: next = {q[WIDTH-2:0], fb}, where fb = XOR of tap bits.
  - Default WIDTH=10 taps are bits 9 and 6 (x^10+x^7+1).
  - Steps only while in INIT. It is not reseeded between fills, so a second fill produces a different sequence.
- XFER (exactly one cycle):
  - Effective address of lane i = Address+i, computed at ADDR_W+1 bits with no truncation before the range check.
  - Range check with WRAP=0: if Address+LANES > DEPTH, no memory write, Q unchanged, AddrErr=1, Ack=0.
  - With WRAP=1: lane address = (Address+i) mod DEPTH; no error unless Address >= DEPTH, which sets AddrErr.
  - Read: Q lanes updated on exit from XFER; Ack=1 in the same cycle Q becomes valid.
  - Write: all LANES words committed in one edge; Ack=1.
  - Latency: Req sampled at edge k; Ack/AddrErr high during cycle k+1; Busy high during cycle k+1. Back in IDLE at edge k+1, so Req can be accepted again at edge k+1.
- Ack and AddrErr are mutually exclusive and never asserted in INIT.
- Access before InitDone is legal; it returns whatever the memory holds.

Decomposition:
- Package weight_store_pkg:
  - state enum (IDLE/INIT/XFER);
  - function lfsr_taps(width) returning the tap mask for widths 4..16;
  - function clog2 helper.
- Sub-module weight_lfsr: WIDTH, SEED, advance enable, state out. Same async active-low Rst.
- Memory and FSM stay in the top module.

Test Plan:
- Reset, pulse InitReq, defaults -> Busy high for 65 cycles, then InitDone=1; read Address=0 gives Q[0..9] = 001,002,004,008,010,020,040,081,102,204.
- Write D[i]=10'h100+i at Address=20, then read Address=20 -> Ack exactly one cycle after each Req; Q[i]=10'h100+i; words 19 and 30 unchanged.
- WRAP=0, Address=60 read or write -> AddrErr pulse, Ack=0, Q and memory unchanged. WRAP=1, write Address=60 -> words 60..64 and 0..4 written.
- InitReq and Req asserted on the same edge -> INIT entered, no Ack; Req during INIT ignored.
- Rst low at fill cycle 30 -> outputs zero immediately, InitDone=0. A new fill then starts from LFSR=SEED, so word0=001.
- Two back-to-back fills -> second fill's word0 equals the LFSR state after 65 steps, not SEED.
